// File: rtl/tt_um_up_down_counter.sv
// Loadable up/down counter: synchronous load beats count enable, which beats hold.
// Asynchronous active-low reset clears the count; wraps modulo 2^WIDTH in both directions.
module tt_um_up_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             set,
   input  logic [WIDTH-1:0] set_value,
   input  logic             up_down,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_next;

   always_comb begin
      count_next = count;
      if (set) begin
         count_next = set_value;
      end else if (enable) begin
         // Carry/borrow fall off the top bit, giving wrap-around with no saturation
         count_next = up_down ? count + WIDTH'(1) : count - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: tb/tb_tt_um_up_down_counter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against an integer modulo-arithmetic reference.
module tb_tt_um_up_down_counter;

   localparam int WIDTH = 4;
   localparam int MOD   = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic             set;
   logic [WIDTH-1:0] set_value;
   logic             up_down;
   logic [WIDTH-1:0] count;

   int checks  = 0;
   int errors  = 0;
   int m       = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   tt_um_up_down_counter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .set       (set),
      .set_value (set_value),
      .up_down   (up_down),
      .count     (count)
   );

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the count is just an integer in [0, MOD) updated by the priority rules
   always @(posedge clk or negedge reset) begin
      if (!reset)       m = 0;
      else if (set)     m = int'(set_value);
      else if (enable)  m = up_down ? (m + 1) % MOD : (m + MOD - 1) % MOD;
   end

   always @(negedge clk) begin
      if (started) check("model_cmp", count, WIDTH'(m));
   end

   task automatic step(input logic s, input logic e, input logic ud,
                       input logic [WIDTH-1:0] v);
      set       = s;
      enable    = e;
      up_down   = ud;
      set_value = v;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [WIDTH-1:0] exp);
      check(name, count, exp);
      check({"model_", name}, WIDTH'(m), exp);
   endtask

   // Pulse reset between edges and confirm the clear is immediate
   task automatic async_reset_pulse(input string name);
      #1 reset = 1'b0;
      #1 check(name, count, '0);
      #1 reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1; set = 1'b0; enable = 1'b0; up_down = 1'b0; set_value = '0;
      #2 reset = 1'b0;
      #1 check("reset_async", count, '0);
      started = 1'b1;
      @(negedge clk);
      #1 reset = 1'b1;

      step(1'b1, 1'b0, 1'b0, 4'b1010);  lit("load", 4'b1010);
      repeat (5) step(1'b0, 1'b1, 1'b1, 4'b0000);
      lit("count_up5", 4'b1111);
      step(1'b0, 1'b1, 1'b1, 4'b0000);  lit("wrap_up", 4'b0000);

      step(1'b1, 1'b0, 1'b0, 4'b0010);  lit("load2", 4'b0010);
      step(1'b0, 1'b1, 1'b0, 4'b0000);  lit("down1", 4'b0001);
      step(1'b0, 1'b1, 1'b0, 4'b0000);  lit("down0", 4'b0000);
      step(1'b0, 1'b1, 1'b0, 4'b0000);  lit("wrap_down", 4'b1111);

      step(1'b0, 1'b0, 1'b1, 4'b0110);  lit("hold1", 4'b1111);
      step(1'b0, 1'b0, 1'b0, 4'b0110);  lit("hold2", 4'b1111);

      step(1'b1, 1'b1, 1'b1, 4'b0101);  lit("set_priority", 4'b0101);
      step(1'b0, 1'b1, 1'b1, 4'b0000);  lit("dir_up", 4'b0110);
      step(1'b0, 1'b1, 1'b0, 4'b0000);  lit("dir_down", 4'b0101);
      step(1'b0, 1'b1, 1'b1, 4'b0000);  lit("dir_up2", 4'b0110);

      async_reset_pulse("reset_mid");
      repeat (5) step(1'b0, 1'b1, 1'b1, 4'b0000);
      lit("after_reset_up5", 4'b0101);

      // Reset held across an edge overrides a pending load
      reset = 1'b0;
      step(1'b1, 1'b1, 1'b1, 4'b1001);  lit("reset_over_set", 4'b0000);
      reset = 1'b1;

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) async_reset_pulse("rand_reset_pulse");
         if ($urandom_range(0, 59) == 0) reset = 1'b0;
         step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, WIDTH'($urandom));
         if (!reset) begin
            check("rand_reset_hold", count, '0);
            reset = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tt_um_up_down_counter.md
TT_UM_UP_DOWN_COUNTER -- requirements
Module: tt_um_up_down_counter

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits; all scenarios below use the default.

Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: count enable, active-high.
REQ-005 The block SHALL have port set, input, 1 bit: synchronous parallel load, active-high.
REQ-006 The block SHALL have port set_value, input, WIDTH bits: load value.
REQ-007 The block SHALL have port up_down, input, 1 bit: direction, 1 = up, 0 = down.
REQ-008 The block SHALL have port count, output, WIDTH bits: current counter value, driven directly from a register.

Function
REQ-009 The block SHALL evaluate control inputs only at rising clk edges while reset is high, in priority order set > enable > hold.
REQ-010 When set=1, the block SHALL load count <= set_value at that edge, regardless of enable and up_down.
REQ-011 When set=0, enable=1 and up_down=1, the block SHALL increment count <= count + 1 modulo 2^WIDTH.
REQ-012 When set=0, enable=1 and up_down=0, the block SHALL decrement count <= count - 1 modulo 2^WIDTH.
REQ-013 When set=0 and enable=0, the block SHALL hold count unchanged.
REQ-014 The block SHALL have a latency of one clock for every operation: the new count is visible right after the edge that samples the control.
REQ-015 At the upper boundary, the block SHALL wrap count from all-ones (4'b1111) to 0 when counting up, with no saturation.
REQ-016 At the lower boundary, the block SHALL wrap count from 0 to all-ones when counting down, with no saturation.
REQ-017 Changing up_down while enable=1 SHALL take effect at the next rising edge, with no dead cycle.
REQ-018 Arithmetic SHALL be unsigned WIDTH-bit; the block SHALL discard carry and borrow.
REQ-019 The block SHALL produce no X on count after the first reset, for any known input combination.

Reset
REQ-020 While reset=0, count SHALL be forced to 0 immediately, independent of clk.
REQ-021 Reset SHALL override set and enable.
REQ-022 Reset asserted mid-count SHALL clear count to 0 immediately.
REQ-023 After reset returns to 1, the first rising edge SHALL apply the normal set/enable/hold rules starting from 0.
REQ-024 The block SHALL have no other state besides count.

Verification
REQ-025 Reset, load, count up: assert reset=0 -> count=0 without a clock edge; deassert; set_value=4'b1010, set=1 for one edge -> count=4'b1010; set=0, enable=1, up_down=1 for 5 edges -> count=4'b1111.
REQ-026 Up wrap: from 4'b1111 with enable=1, up_down=1, one edge -> count=4'b0000.
REQ-027 Down count and down wrap: load 4'b0010, enable=1, up_down=0, 3 edges -> count sequence 4'b0001, 4'b0000, 4'b1111.
REQ-028 Hold: enable=0, set=0 for 2 edges -> count unchanged; toggling up_down during this has no effect.
REQ-029 Set priority: enable=1, up_down=1, set=1, set_value=4'b0101 -> count=4'b0101 after one edge, not an incremented value.
REQ-030 Asynchronous reset mid-operation: while counting, drive reset=0 between clock edges -> count=0 immediately; release, enable=1, up_down=1, 5 edges -> count=4'b0101.
